fwd_history: RTL and testbench
==============================

FWD_HISTORY -- requirements
Module: fwd_history

Interface
REQ-001 Parameter AW, default 4, register/word address width.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter DEPTH, default 3, registered write-history entries (legal 1..8).
REQ-004 Parameter NRD, default 3, independent read-query ports (legal 1..4).
REQ-005 Parameter ZERO_REG, default 1, when 1 address 0 is hard-wired zero.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 clr  in  1  synchronous history invalidate.
REQ-010 wen  in  1  write-commit strobe from the write-back stage.
REQ-011 waddr  in  AW  write address.
REQ-012 wdata  in  DW  write data.
REQ-013 rd_addr  in  NRD*AW  query addresses, port i in bits [i*AW +: AW].
REQ-014 rd_fallback  in  NRD*DW  backing-store read data per port.
REQ-015 rd_data  out  NRD*DW  resolved read data per port.
REQ-016 rd_hit  out  NRD  port i result came from the live write or history.
REQ-017 hist_valid  out  DEPTH  valid bit of history entries 1..DEPTH (bit k-1 = entry k).

Function
REQ-018 Effective write: wen == 1 exactly; X/Z on wen is no-write; with ZERO_REG=1, waddr == 0 is no-write.
REQ-019 Stage 0 is the live effective write (wen/waddr/wdata, combinational, same cycle).
REQ-020 Each rising edge: entry 1 <= stage 0 (valid = effective write), entry k <= entry k-1 for k = 2..DEPTH; oldest entry discarded.
REQ-021 Entries age every cycle regardless of wen; entry k holds the write committed k cycles earlier.
REQ-022 Read resolution per port, 0-cycle combinational: ZERO_REG=1 and rd_addr == 0 -> rd_data 0, rd_hit 0.
REQ-023 Otherwise, first match in priority order stage 0, entry 1, ..., entry DEPTH (valid and address equal) supplies rd_data, rd_hit 1.
REQ-024 No match -> rd_data = rd_fallback of that port, rd_hit 0.
REQ-025 Ports are independent; identical addresses on several ports give identical results.
REQ-026 clr: on the edge where clr == 1, entries 2..DEPTH valid <= 0; entry 1 still captures the stage-0 write of that cycle.
REQ-027 clr does not affect combinational resolution in its own cycle (history still visible until the edge).
REQ-028 clr and wen in same cycle: after the edge only that write remains valid.
REQ-029 Invalid entries never match, whatever their stored address/data.

Reset
REQ-030 rst_n low asynchronously clears all entry valid bits, addresses and data to 0; hist_valid = 0 immediately.
REQ-031 During reset, rd_data equals rd_fallback (or 0 for address 0 with ZERO_REG=1), rd_hit = 0.
REQ-032 Deassertion mid-stream: first edge after release records normally; no pre-reset write is ever returned.

Verification
REQ-033 Write r3=0x1234, query port0 addr 3 same cycle, fallback 0xAAAA -> rd_data 0x1234, rd_hit 1; cycles 1..3 later still 0x1234; cycle 4 -> 0xAAAA, rd_hit 0.
REQ-034 Writes r5=0x0001, r5=0x0002, r5=0x0003 on consecutive cycles, then query r5 with no write -> 0x0003 (newest wins); query while third write live -> 0x0003 from stage 0.
REQ-035 ZERO_REG=1: wen=1 waddr 0 wdata 0xFFFF -> hist_valid unchanged next cycle; query addr 0 -> 0x0000, rd_hit 0.
REQ-036 History r1=0x0011 (entry 2), r2=0x0022 (entry 1); assert clr with write r4=0x0044 -> after edge hist_valid=3'b001, r1/r2 queries return fallback, r4 returns 0x0044.
REQ-037 Three ports query r7, r7, r9 with entry 3 holding r7=0xBEEF and fallbacks 0x1111/0x2222/0x3333 -> 0xBEEF, 0xBEEF, 0x3333; rd_hit 3'b011.
REQ-038 Fill history, pull rst_n low between edges -> hist_valid 0 immediately, all queries return fallback; wen=x for one cycle -> no entry recorded.

Source files
------------

// File: rtl/fwd_history.sv
// Write-history forwarding buffer: the live write plus the last DEPTH committed writes
// resolve register reads combinationally, newest match first, with fallback to the backing store.
module fwd_history #(
    parameter int AW       = 4,
    parameter int DW       = 16,
    parameter int DEPTH    = 3,
    parameter int NRD      = 3,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               wen,
    input  logic [AW-1:0]      waddr,
    input  logic [DW-1:0]      wdata,
    input  logic [NRD*AW-1:0]  rd_addr,
    input  logic [NRD*DW-1:0]  rd_fallback,
    output logic [NRD*DW-1:0]  rd_data,
    output logic [NRD-1:0]     rd_hit,
    output logic [DEPTH-1:0]   hist_valid
);

    // Index k of each array holds history entry k+1.
    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0] data_q, data_d;
    logic                     we;

    // Only a clean 1 on wen commits; X/Z and writes to the zero register do not,
    // and nothing is forwarded while reset is held.
    always_comb begin
        we = rst_n && (wen === 1'b1) && !((ZERO_REG != 0) && (waddr == '0));
    end

    always_comb begin
        vld_d     = '0;
        addr_d    = addr_q;
        data_d    = data_q;
        vld_d[0]  = we;
        addr_d[0] = waddr;
        data_d[0] = wdata;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            vld_d[k]  = vld_q[k-1] & ~clr;
            addr_d[k] = addr_q[k-1];
            data_d[k] = data_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        logic [DW-1:0] val;
        logic          hit;
        rd_data = '0;
        rd_hit  = '0;
        a       = '0;
        val     = '0;
        hit     = 1'b0;
        for (int unsigned p = 0; p < NRD; p++) begin
            a   = rd_addr[p*AW +: AW];
            val = rd_fallback[p*DW +: DW];
            hit = 1'b0;
            if ((ZERO_REG != 0) && (a == '0)) begin
                val = '0;
            end else if (we && (waddr == a)) begin
                hit = 1'b1;
                val = wdata;
            end else begin
                // Scan oldest-last; the first valid match is the newest commit.
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    if (!hit && vld_q[k] && (addr_q[k] == a)) begin
                        hit = 1'b1;
                        val = data_q[k];
                    end
                end
            end
            rd_data[p*DW +: DW] = val;
            rd_hit[p]           = hit;
        end
    end

    assign hist_valid = vld_q;

endmodule

// File: tb/tb_fwd_history.sv
// Directed bench for fwd_history: hand-computed expectations for forwarding, aging,
// clear, zero register, multi-port lookup and asynchronous reset.
module tb_fwd_history;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 3;
    localparam int NRD   = 3;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_fallback;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_hit;
    logic [DEPTH-1:0]  hist_valid;

    int n_tests;
    int n_fail;

    fwd_history #(
        .AW(AW),
        .DW(DW),
        .DEPTH(DEPTH),
        .NRD(NRD),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .wen(wen),
        .waddr(waddr),
        .wdata(wdata),
        .rd_addr(rd_addr),
        .rd_fallback(rd_fallback),
        .rd_data(rd_data),
        .rd_hit(rd_hit),
        .hist_valid(hist_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] fb);
        rd_addr[p*AW +: AW]     = a;
        rd_fallback[p*DW +: DW] = fb;
    endtask

    task automatic drive_wr(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen   = w;
        waddr = a;
        wdata = d;
    endtask

    function automatic logic [DW-1:0] port_data(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        rd_addr     = '0;
        rd_fallback = '0;
        drive_wr(1'b0, 4'd0, 16'h0000);
        set_port(0, 4'd3, 16'hAAAA);
        set_port(1, 4'd0, 16'h5555);
        #2;
        check("rst_hist_valid", 32'(hist_valid), 32'h0);
        check("rst_port0_fb", 32'(port_data(0)), 32'hAAAA);
        check("rst_port1_zero", 32'(port_data(1)), 32'h0000);
        check("rst_hit", 32'(rd_hit), 32'h0);
        step();
        rst_n = 1'b1;

        // T0: live write r3 forwarded in the same cycle
        drive_wr(1'b1, 4'd3, 16'h1234);
        #2;
        check("t0_stage0_data", 32'(port_data(0)), 32'h1234);
        check("t0_stage0_hit", 32'(rd_hit), 32'b001);
        step();
        drive_wr(1'b0, 4'd0, 16'h0000);
        #2;
        check("t1_entry1_data", 32'(port_data(0)), 32'h1234);
        check("t1_hist", 32'(hist_valid), 32'b001);
        step();
        #2;
        check("t2_entry2_data", 32'(port_data(0)), 32'h1234);
        check("t2_hist", 32'(hist_valid), 32'b010);
        step();
        #2;
        check("t3_entry3_data", 32'(port_data(0)), 32'h1234);
        check("t3_hist", 32'(hist_valid), 32'b100);
        check("t3_hit", 32'(rd_hit), 32'b001);
        step();

        // T4: r3 aged out; start r5 sequence
        drive_wr(1'b1, 4'd5, 16'h0001);
        #2;
        check("t4_aged_out_data", 32'(port_data(0)), 32'hAAAA);
        check("t4_aged_out_hit", 32'(rd_hit), 32'b000);
        check("t4_hist", 32'(hist_valid), 32'b000);
        step();
        drive_wr(1'b1, 4'd5, 16'h0002);
        step();
        drive_wr(1'b1, 4'd5, 16'h0003);
        set_port(1, 4'd5, 16'h5555);
        #2;
        check("t6_newest_live", 32'(port_data(1)), 32'h0003);
        check("t6_hist", 32'(hist_valid), 32'b011);
        step();
        drive_wr(1'b0, 4'd0, 16'h0000);
        #2;
        check("t7_newest_hist", 32'(port_data(1)), 32'h0003);
        check("t7_hist", 32'(hist_valid), 32'b111);
        step();

        // T8: write to r0 must not record
        drive_wr(1'b1, 4'd0, 16'hFFFF);
        set_port(2, 4'd0, 16'h7777);
        #2;
        check("t8_zero_data", 32'(port_data(2)), 32'h0000);
        check("t8_zero_hit", 32'(rd_hit), 32'b010);
        check("t8_hist", 32'(hist_valid), 32'b110);
        step();
        drive_wr(1'b1, 4'd1, 16'h0011);
        #2;
        check("t9_zero_no_record", 32'(hist_valid), 32'b100);
        check("t9_entry3_r5", 32'(port_data(1)), 32'h0003);
        step();
        drive_wr(1'b1, 4'd2, 16'h0022);
        step();

        // T11: clr together with a write to r4
        drive_wr(1'b1, 4'd4, 16'h0044);
        clr = 1'b1;
        set_port(0, 4'd1, 16'hA001);
        set_port(1, 4'd2, 16'hB002);
        set_port(2, 4'd4, 16'hC004);
        #2;
        check("t11_hist", 32'(hist_valid), 32'b011);
        check("t11_clr_r1_visible", 32'(port_data(0)), 32'h0011);
        check("t11_clr_r2_visible", 32'(port_data(1)), 32'h0022);
        check("t11_r4_live", 32'(port_data(2)), 32'h0044);
        step();
        clr = 1'b0;
        drive_wr(1'b1, 4'd7, 16'hBEEF);
        #2;
        check("t12_hist_after_clr", 32'(hist_valid), 32'b001);
        check("t12_r1_fb", 32'(port_data(0)), 32'hA001);
        check("t12_r2_fb", 32'(port_data(1)), 32'hB002);
        check("t12_r4_hist", 32'(port_data(2)), 32'h0044);
        check("t12_hit", 32'(rd_hit), 32'b100);
        step();
        drive_wr(1'b0, 4'd9, 16'h9999);
        step();
        step();

        // T15: r7 in entry 3, invalid entries 1/2 carry address 9
        set_port(0, 4'd7, 16'h1111);
        set_port(1, 4'd7, 16'h2222);
        set_port(2, 4'd9, 16'h3333);
        #2;
        check("t15_hist", 32'(hist_valid), 32'b100);
        check("t15_port0", 32'(port_data(0)), 32'hBEEF);
        check("t15_port1", 32'(port_data(1)), 32'hBEEF);
        check("t15_port2_invalid", 32'(port_data(2)), 32'h3333);
        check("t15_hit", 32'(rd_hit), 32'b011);

        // Fill history, then reset mid-cycle
        drive_wr(1'b1, 4'd6, 16'h0066);
        step();
        drive_wr(1'b1, 4'd8, 16'h0088);
        step();
        drive_wr(1'b1, 4'd10, 16'h00AA);
        step();
        drive_wr(1'b0, 4'd0, 16'h0000);
        set_port(0, 4'd6, 16'h0F06);
        set_port(1, 4'd8, 16'h0F08);
        set_port(2, 4'd10, 16'h0F0A);
        #2;
        check("t18_hist_full", 32'(hist_valid), 32'b111);
        check("t18_r10_hit", 32'(port_data(2)), 32'h00AA);
        rst_n = 1'b0;
        #1;
        check("async_rst_hist", 32'(hist_valid), 32'b000);
        check("async_rst_p0", 32'(port_data(0)), 32'h0F06);
        check("async_rst_p1", 32'(port_data(1)), 32'h0F08);
        check("async_rst_p2", 32'(port_data(2)), 32'h0F0A);
        check("async_rst_hit", 32'(rd_hit), 32'b000);
        step();
        rst_n = 1'b1;
        wen   = 1'bx;
        waddr = 4'd6;
        wdata = 16'h0666;
        #2;
        check("wen_x_no_fwd", 32'(port_data(0)), 32'h0F06);
        step();
        drive_wr(1'b1, 4'd11, 16'h0BBB);
        #2;
        check("wen_x_no_record", 32'(hist_valid), 32'b000);
        check("wen_x_r6_fb", 32'(port_data(0)), 32'h0F06);
        step();
        drive_wr(1'b0, 4'd0, 16'h0000);
        set_port(1, 4'd11, 16'h0F0B);
        #2;
        check("post_rst_hist", 32'(hist_valid), 32'b001);
        check("post_rst_r11", 32'(port_data(1)), 32'h0BBB);
        check("post_rst_r6_fb", 32'(port_data(0)), 32'h0F06);
        check("post_rst_hit", 32'(rd_hit), 32'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
